// File: rtl/perm_rsp_pkg.sv
// perm_rsp_pkg: shared definitions for the permutation response buffer.
//   state_e   - buffer FSM states (EMPTY, FILL, FULL, SEND)
//   req_t     - decoded read request (first byte, one-past-last byte, error)
//   calc_req  - turns a raw (offset, length) request into a req_t
package perm_rsp_pkg;

  localparam int BLK_BYTES  = 200;
  localparam int BLK_WORDS  = 25;
  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    SEND  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] start;  // first byte offset to send
    logic [7:0] fin;    // one past the last byte offset (max 200)
    logic       bad;    // malformed request, raises err
  } req_t;

  // Malformed requests are still served: an empty or out-of-block request
  // degenerates to the single last byte, an overrun is clipped at the block end.
  function automatic req_t calc_req(input logic [7:0] off, input logic [7:0] len);
    req_t       r;
    logic [8:0] sum;
    sum   = {1'b0, off} + {1'b0, len};
    r.bad = (len == 8'd0) || (off > 8'(BLK_BYTES - 1)) || (sum > 9'(BLK_BYTES));
    if ((len == 8'd0) || (off > 8'(BLK_BYTES - 1))) begin
      r.start = 8'(BLK_BYTES - 1);
      r.fin   = 8'(BLK_BYTES);
    end else if (sum > 9'(BLK_BYTES)) begin
      r.start = off;
      r.fin   = 8'(BLK_BYTES);
    end else begin
      r.start = off;
      r.fin   = sum[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/perm_rsp_mem.sv
// perm_rsp_mem: 25 x 64-bit block storage, one word write port and one
// combinational byte read port (byte k = word[k/8] bits [8*(k%8)+:8]).
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - word index 0..24
//   wdata_i  - word to write
//   raddr_i  - byte offset 0..199
//   rdata_o  - addressed byte (0 for offsets beyond the block)
// Contents are deliberately not reset.
module perm_rsp_mem
  import perm_rsp_pkg::*;
(
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [7:0]  rdata_o
);

  logic [63:0] mem_q [BLK_WORDS];
  logic [4:0]  rword_s;
  logic [2:0]  rsel_s;

  assign rword_s = raddr_i[7:3];
  assign rsel_s  = raddr_i[2:0];

  // word write port
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < 5'(BLK_WORDS))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // little-endian byte select; the one-past-end prefetch address reads as 0
  always_comb begin
    rdata_o = 8'd0;
    if (rword_s < 5'(BLK_WORDS)) begin
      rdata_o = mem_q[rword_s][{rsel_s, 3'b000} +: 8];
    end else begin
      rdata_o = 8'd0;
    end
  end

endmodule

// File: rtl/perm_rsp_buf.sv
// perm_rsp_buf: captures one 25-word (200-byte) block from the permutation
// engine and serves byte-granular read requests from it.
//   clk, rst            - clock, asynchronous active-high reset
//   pushout/firstout/dout - engine word stream (firstout marks word 0)
//   stopout             - 1 while the block is held; pushes are then ignored
//   req_valid/req_ready/req_off/req_len - read request handshake
//   byte_valid/byte_ready/byte_data/byte_last - response byte stream
//   blk_full            - a complete block is held
//   err                 - sticky protocol error
// Build option PERM_RSP_BUF_KEEP_EN: the block is retained after a read
// (back to FULL) and an extra input clr releases it from FULL to EMPTY.
module perm_rsp_buf
  import perm_rsp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pushout,
  input  logic        firstout,
  input  logic [63:0] dout,
  output logic        stopout,
  input  logic        req_valid,
  input  logic [7:0]  req_off,
  input  logic [7:0]  req_len,
  output logic        req_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_last,
  input  logic        byte_ready,
  output logic        blk_full,
  output logic        err
`ifdef PERM_RSP_BUF_KEEP_EN
  ,
  input  logic        clr
`endif
);

`ifdef PERM_RSP_BUF_KEEP_EN
  localparam logic KEEP = 1'b1;
  logic clr_s;
  assign clr_s = clr;
`else
  localparam logic KEEP = 1'b0;
  logic clr_s;
  assign clr_s = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  end_q, end_d;
  logic        bv_q, bv_d;
  logic [7:0]  bd_q, bd_d;
  logic        bl_q, bl_d;
  logic        err_q, err_d;

  logic        we_s;
  logic [4:0]  waddr_s;
  logic [7:0]  raddr_s;
  logic [7:0]  rbyte_s;
  req_t        req_s;

  assign req_s = calc_req(req_off, req_len);

  perm_rsp_mem u_mem (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (dout),
    .raddr_i (raddr_s),
    .rdata_o (rbyte_s)
  );

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= 5'd0;
      ptr_q   <= 8'd0;
      end_q   <= 8'd0;
      bv_q    <= 1'b0;
      bd_q    <= 8'd0;
      bl_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      bv_q    <= bv_d;
      bd_q    <= bd_d;
      bl_q    <= bl_d;
      err_q   <= err_d;
    end
  end

  // next-state, storage write and byte prefetch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    bv_d    = bv_q;
    bd_d    = bd_q;
    bl_d    = bl_q;
    err_d   = err_q;
    we_s    = 1'b0;
    waddr_s = 5'd0;
    // in SEND the read port looks one byte ahead so the next byte is ready
    raddr_s = ptr_q + 8'd1;
    case (state_q)
      EMPTY: begin
        if (pushout && firstout) begin
          we_s    = 1'b1;
          waddr_s = 5'd0;
          cnt_d   = 5'd1;
          state_d = FILL;
        end else if (pushout) begin
          err_d = 1'b1;
        end else begin
          state_d = EMPTY;
        end
      end
      FILL: begin
        if (pushout && firstout) begin
          we_s    = 1'b1;
          waddr_s = 5'd0;
          cnt_d   = 5'd1;
          err_d   = 1'b1;
        end else if (pushout) begin
          we_s    = 1'b1;
          waddr_s = cnt_q;
          if (cnt_q == 5'(BLK_WORDS - 1)) begin
            cnt_d   = 5'd0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          state_d = FILL;
        end
      end
      FULL: begin
        raddr_s = req_s.start;
        if (clr_s) begin
          state_d = EMPTY;
        end else if (req_valid) begin
          err_d   = err_q | req_s.bad;
          ptr_d   = req_s.start;
          end_d   = req_s.fin;
          bv_d    = 1'b1;
          bd_d    = rbyte_s;
          bl_d    = (req_s.start == (req_s.fin - 8'd1));
          state_d = SEND;
        end else begin
          state_d = FULL;
        end
      end
      SEND: begin
        if (bv_q && byte_ready) begin
          if (bl_q) begin
            bv_d    = 1'b0;
            bl_d    = 1'b0;
            state_d = KEEP ? FULL : EMPTY;
          end else begin
            ptr_d = ptr_q + 8'd1;
            bd_d  = rbyte_s;
            bl_d  = ((ptr_q + 8'd1) == (end_q - 8'd1));
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign stopout    = (state_q == FULL) || (state_q == SEND);
  // clr wins over a simultaneous request, so the request is not acknowledged
  assign req_ready  = (state_q == FULL) && !clr_s;
  assign blk_full   = (state_q == FULL) || (state_q == SEND);
  assign byte_valid = bv_q;
  assign byte_data  = bd_q;
  assign byte_last  = bl_q;
  assign err        = err_q;

endmodule

// File: doc/perm_rsp_buf.md
PERM_RSP_BUF -- requirements
Module: perm_rsp_buf

Interface
REQ-001 clk  input  1  clock, all state on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 pushout  input  1  permutation engine output word valid.
REQ-004 firstout  input  1  marks word 0 of a 25-word block; meaningful only with pushout.
REQ-005 dout  input  64  permutation output word.
REQ-006 stopout  output  1  back-pressure to the permutation engine; 1 = words ignored.
REQ-007 req_valid  input  1  read-response request from the NOC interface.
REQ-008 req_off  input  8  starting byte offset in the block, 0..199.
REQ-009 req_len  input  8  byte count, 1..200.
REQ-010 req_ready  output  1  request accepted when req_valid and req_ready are both 1.
REQ-011 byte_valid  output  1  response byte valid.
REQ-012 byte_data  output  8  response byte.
REQ-013 byte_last  output  1  final byte of the request.
REQ-014 byte_ready  input  1  consumer accepts the byte when byte_valid and byte_ready are both 1.
REQ-015 blk_full  output  1  complete 200-byte block held.
REQ-016 err  output  1  sticky protocol error; cleared only by rst.

Function
REQ-017 States: EMPTY, FILL, FULL, SEND.
REQ-018 Output decode: stopout=0 in EMPTY/FILL, 1 otherwise; req_ready=1 only in FULL; blk_full=1 in FULL/SEND.
REQ-019 EMPTY: pushout&firstout writes dout to word 0 and goes to FILL with word count 1; pushout without firstout is dropped and sets err.
REQ-020 FILL: pushout writes word[count] and increments count; on writing word 24, go to FULL next cycle.
REQ-021 FILL: pushout&firstout restarts the block (dout to word 0, count=1) and sets err.
REQ-022 Pushes while stopout=1 are ignored and leave storage unchanged.
REQ-023 Byte k of the block is word[k/8] bits [8*(k%8)+7 : 8*(k%8)] (little-endian).
REQ-024 FULL: an accepted request latches end=min(off+len,200), with the sum computed 9 bits wide, and goes to SEND.
REQ-025 A request with len=0, off>199 or off+len>200 sets err; it is still accepted, with len=0 or off>199 giving a single byte at offset 199.
REQ-026 SEND: byte_valid is registered, asserted the cycle after acceptance, and held with stable data until accepted.
REQ-027 SEND: one byte per cycle while byte_ready=1; byte_last=1 exactly when the pointer equals end-1.
REQ-028 Last byte accepted: go to EMPTY (block released, stopout drops next cycle), except as in REQ-033.
REQ-029 pushout during SEND/FULL is ignored per REQ-022; no error.

Reset
REQ-030 On rst: state EMPTY, counters 0, stopout=0, req_ready=0, byte_valid=0, byte_last=0, byte_data=0, blk_full=0, err=0.
REQ-031 rst asserted mid-FILL or mid-SEND aborts immediately: the partial block is discarded and no further bytes are emitted.
REQ-032 Storage contents are not reset, and are not observable until refilled.

Configuration
REQ-033 With PERM_RSP_BUF_KEEP_EN defined: after the last byte, return to FULL (block retained for repeat reads), and input clr (1 bit) returns FULL to EMPTY.
REQ-034 Without the macro: clr port absent; behaviour per REQ-028.

Structure
REQ-035 Package perm_rsp_pkg: state enum, BLK_BYTES=200, BLK_WORDS=25, WORD_BYTES=8.
REQ-036 Sub-module perm_rsp_mem: 25x64 single-write, byte-addressed single-read storage.

Verification
REQ-037 25 pushes of word i = 64'h0101010101010101*i, first on i=0 -> blk_full=1 after the 25th; stopout=1 the following cycle.
REQ-038 Request off=8, len=3 -> bytes 01,01,01, byte_last on the third, then state EMPTY and stopout=0.
REQ-039 byte_ready held low 4 cycles mid-SEND -> byte_data stable and no byte lost or duplicated.
REQ-040 Request off=198, len=5 -> err=1, two bytes (offsets 198,199) sent, last on offset 199.
REQ-041 pushout without firstout in EMPTY -> err=1, nothing stored; a firstout at word 10 -> restart, block full only after 25 more words.
REQ-042 rst pulse during SEND after 2 of 10 bytes -> byte_valid=0 immediately and all outputs at reset values.
